// File: rtl/top.sv
// Four-core compute array. A DEPTH-word register memory is split into four
// equal banks; after reset each core squares every word of its own bank in
// place, then raises its end_process flag. Once all cores are done, any word
// can be read back through addr_tb/result with one cycle of latency.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   addr_tb       read-back word address (ignored until all cores are done)
//   result        registered read-back data (0 for out-of-range addresses)
//   end_process1  core 1 (bank 0) finished
//   end_process2  core 2 (bank 1) finished
//   end_process3  core 3 (bank 2) finished
//   end_process4  core 4 (bank 3) finished
module top #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] addr_tb,
    output logic [DW-1:0] result,
    output logic          end_process1,
    output logic          end_process2,
    output logic          end_process3,
    output logic          end_process4
);

    localparam int unsigned NCORE = 4;
    localparam int unsigned B     = DEPTH / NCORE;
    localparam int unsigned PW    = $clog2(B);
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        RD   = 2'd0,
        WR   = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [DW-1:0]    mem [DEPTH];

    state_t           state_q [NCORE];
    state_t           state_d [NCORE];
    logic [PW-1:0]    ptr_q   [NCORE];
    logic [PW-1:0]    ptr_d   [NCORE];
    logic [DW-1:0]    opnd_q  [NCORE];
    logic [DW-1:0]    opnd_d  [NCORE];
    logic [NCORE-1:0] done_q;
    logic [NCORE-1:0] done_d;

    logic [NCORE-1:0] wr_en_c;
    logic [AW-1:0]    bank_addr_c [NCORE];
    logic [DW-1:0]    sq_c        [NCORE];

    // Per-core next state: read the operand, then write back its square.
    always_comb begin
        for (int c = 0; c < NCORE; c++) begin
            state_d[c]     = state_q[c];
            ptr_d[c]       = ptr_q[c];
            opnd_d[c]      = opnd_q[c];
            done_d[c]      = done_q[c];
            wr_en_c[c]     = 1'b0;
            bank_addr_c[c] = AW'(c * B) + AW'(ptr_q[c]);
            // Product truncated to the data width.
            sq_c[c]        = DW'((2*DW)'(opnd_q[c]) * (2*DW)'(opnd_q[c]));

            case (state_q[c])
                RD: begin
                    opnd_d[c]  = mem[bank_addr_c[c]];
                    state_d[c] = WR;
                end
                WR: begin
                    wr_en_c[c] = 1'b1;
                    if (ptr_q[c] == PW'(B - 1)) begin
                        state_d[c] = DONE;
                        done_d[c]  = 1'b1;
                    end else begin
                        ptr_d[c]   = ptr_q[c] + PW'(1);
                        state_d[c] = RD;
                    end
                end
                DONE: begin
                    state_d[c] = DONE;
                end
                default: begin
                    state_d[c] = RD;
                end
            endcase
        end
    end

    // State, memory and read-back registers; reset loads mem[a] = a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= DW'(a);
            end
            for (int c = 0; c < NCORE; c++) begin
                state_q[c] <= RD;
                ptr_q[c]   <= '0;
                opnd_q[c]  <= '0;
            end
            done_q <= '0;
            result <= '0;
        end else begin
            for (int c = 0; c < NCORE; c++) begin
                state_q[c] <= state_d[c];
                ptr_q[c]   <= ptr_d[c];
                opnd_q[c]  <= opnd_d[c];
                // Banks are disjoint, so core writes never collide.
                if (wr_en_c[c]) begin
                    mem[bank_addr_c[c]] <= sq_c[c];
                end
            end
            done_q <= done_d;
            if (&done_q) begin
                result <= (addr_tb < DW'(DEPTH)) ? mem[addr_tb[AW-1:0]] : '0;
            end
        end
    end

    assign end_process1 = done_q[0];
    assign end_process2 = done_q[1];
    assign end_process3 = done_q[2];
    assign end_process4 = done_q[3];

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the four-core array: stimulus pushes expected flag and
// result values tagged with the clock edge they are due after; a monitor on
// the falling edge pops and compares everything that has come due.
module tb_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr_tb;
    logic [11:0] result;
    logic        end_process1;
    logic        end_process2;
    logic        end_process3;
    logic        end_process4;

    top #(.DEPTH(64), .DW(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_tb      (addr_tb),
        .result       (result),
        .end_process1 (end_process1),
        .end_process2 (end_process2),
        .end_process3 (end_process3),
        .end_process4 (end_process4)
    );

    always #5 clk = ~clk;

    // Free-running count of rising edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          kind;   // 0: result, 1: flags {4,3,2,1}
        logic [11:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int due, input int kind, input logic [11:0] v, input string n);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            logic [11:0] act;
            e = sb.pop_front();
            if (e.kind == 1)
                act = 12'({end_process4, end_process3, end_process2, end_process1});
            else
                act = result;
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s at edge %0d: got %0d expected %0d", e.name, cyc, act, e.exp);
            end
        end
    end

    // Expect a full processing run starting at edge base+1.
    task automatic expect_run(input int base, input logic [11:0] res_after);
        for (int k = 1; k <= 32; k++) begin
            push(base + k, 1, (k == 32) ? 12'hF : 12'h0, "flags_run");
            push(base + k, 0, 12'd0, "result_busy");
        end
        push(base + 33, 1, 12'hF, "flags_hold");
        push(base + 33, 0, res_after, "result_first");
    endtask

    int          base;
    int          dir_addr [6] = '{5, 63, 0, 40, 64, 4095};
    int          dir_exp  [6] = '{25, 3969, 0, 1600, 0, 0};

    initial begin
        rst_n   = 1'b0;
        addr_tb = 12'd10;
        #1;
        push(cyc + 1, 1, 12'h0, "flags_reset");
        push(cyc + 1, 0, 12'd0, "result_reset");
        step(); step(); step();
        rst_n = 1'b1;
        base  = cyc;
        // addr_tb held at 10 through processing: 0 until done, then 100.
        expect_run(base, 12'd100);
        while (cyc < base + 33) step();

        // Directed read-back, including out-of-range addresses.
        for (int i = 0; i < 6; i++) begin
            addr_tb = 12'(dir_addr[i]);
            push(cyc + 1, 0, 12'(dir_exp[i]), "readback_dir");
            step();
        end

        // Sweep every word.
        for (int a = 0; a < 64; a++) begin
            addr_tb = 12'(a);
            push(cyc + 1, 0, 12'(a * a), "readback_sweep");
            step();
        end
        step(); step();

        // Asynchronous reset from the done state clears flags immediately.
        rst_n = 1'b0;
        push(cyc, 1, 12'h0, "flags_async_clear");
        push(cyc, 0, 12'd0, "result_async_clear");
        step(); step(); step();
        rst_n = 1'b1;
        base  = cyc;
        for (int k = 1; k <= 15; k++) push(base + k, 1, 12'h0, "flags_partial");
        while (cyc < base + 15) step();

        // Reset mid-processing, then a full clean run.
        rst_n = 1'b0;
        push(cyc, 1, 12'h0, "flags_midreset");
        step(); step(); step();
        rst_n   = 1'b1;
        addr_tb = 12'd7;
        base    = cyc;
        expect_run(base, 12'd49);
        while (cyc < base + 33) step();
        addr_tb = 12'd15;
        push(cyc + 1, 0, 12'd225, "readback_after_reset");
        step();
        addr_tb = 12'd16;
        push(cyc + 1, 0, 12'd256, "readback_bank1_start");
        step();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
